pipeline_stage_chain: RTL and testbench

//  Generic N-stage pipeline register chain that replaces hand-written per-stage latches.

---
 rtl/pipeline_stage_chain.sv | 115 +++++++++++
 tb/tb_pipeline_stage_chain.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_chain.sv
// Generic N-stage pipeline register chain with per-stage stall/flush,
// bubble insertion on stall boundaries and a saturating hold counter.
module pipeline_stage_chain #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STAGES = 4,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    output logic [STAGES*WIDTH-1:0] stage_data,
    output logic [STAGES-1:0]       stage_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [CNT_W-1:0]        hold_cnt,
    input  logic                    hold_cnt_clr
);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] prev_hold;
    logic [STAGES-1:0] prev_valid;
    logic [WIDTH-1:0]  prev_data [STAGES];

    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [CNT_W-1:0]  hold_cnt_q;
    logic [CNT_W-1:0]  hold_cnt_d;

    // A stall anywhere freezes everything upstream of it.
    always_comb begin
        hold = '0;
        hold[STAGES-1] = stall[STAGES-1];
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            hold[k] = stall[k] | hold[k+1];
        end
    end

    always_comb begin
        prev_hold = '0;
        prev_valid = '0;
        prev_data[0] = in_data;
        prev_valid[0] = in_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            prev_hold[k] = hold[k-1];
            prev_valid[k] = valid_q[k-1];
            prev_data[k] = data_q[k-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < int'(STAGES); k++) begin
            data_d[k] = data_q[k];
            if (flush[k]) begin
                valid_d[k] = 1'b0;
                data_d[k] = BUBBLE_VAL;
            end else if (hold[k]) begin
                valid_d[k] = valid_q[k];
            end else if (prev_hold[k]) begin
                valid_d[k] = 1'b0;
                data_d[k] = BUBBLE_VAL;
            end else begin
                valid_d[k] = prev_valid[k];
                data_d[k] = prev_valid[k] ? prev_data[k]
                                          : BUBBLE_VAL;
            end
        end
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (hold_cnt_clr) begin
            hold_cnt_d = '0;
        end else if (hold[0] && (hold_cnt_q != {CNT_W{1'b1}})) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            hold_cnt_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                data_q[k] <= BUBBLE_VAL;
            end
        end else begin
            valid_q <= valid_d;
            hold_cnt_q <= hold_cnt_d;
            for (int k = 0; k < int'(STAGES); k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    always_comb begin
        stage_data = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            stage_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    assign in_ready    = ~hold[0];
    assign stage_valid = valid_q;
    assign out_data    = data_q[STAGES-1];
    assign out_valid   = valid_q[STAGES-1];
    assign hold_cnt    = hold_cnt_q;

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Directed bench for pipeline_stage_chain: a 4-stage build and a
// 1-stage build, checked against hand-computed expectations.
module tb_pipeline_stage_chain;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] a_in;
    logic        a_iv;
    logic        a_rdy;
    logic [3:0]  a_stall;
    logic [3:0]  a_flush;
    logic [127:0] a_sd;
    logic [3:0]  a_sv;
    logic [31:0] a_out;
    logic        a_ov;
    logic [15:0] a_cnt;
    logic        a_clr;

    logic [31:0] b_in;
    logic        b_iv;
    logic        b_rdy;
    logic [0:0]  b_stall;
    logic [0:0]  b_flush;
    logic [31:0] b_sd;
    logic [0:0]  b_sv;
    logic [31:0] b_out;
    logic        b_ov;
    logic [15:0] b_cnt;
    logic        b_clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    pipeline_stage_chain #(
        .WIDTH(32), .STAGES(4), .BUBBLE_VAL(32'h0), .CNT_W(16)
    ) dut_a (
        .CLK(CLK), .nRST(nRST),
        .in_data(a_in), .in_valid(a_iv), .in_ready(a_rdy),
        .stall(a_stall), .flush(a_flush),
        .stage_data(a_sd), .stage_valid(a_sv),
        .out_data(a_out), .out_valid(a_ov),
        .hold_cnt(a_cnt), .hold_cnt_clr(a_clr)
    );

    pipeline_stage_chain #(
        .WIDTH(32), .STAGES(1), .BUBBLE_VAL(32'h0), .CNT_W(16)
    ) dut_b (
        .CLK(CLK), .nRST(nRST),
        .in_data(b_in), .in_valid(b_iv), .in_ready(b_rdy),
        .stall(b_stall), .flush(b_flush),
        .stage_data(b_sd), .stage_valid(b_sv),
        .out_data(b_out), .out_valid(b_ov),
        .hold_cnt(b_cnt), .hold_cnt_clr(b_clr)
    );

    typedef struct {
        logic [3:0]  stall;
        logic [3:0]  flush;
        logic [31:0] din;
        logic        iv;
        logic [31:0] e_out;
        logic        e_ov;
        logic [3:0]  e_sv;
        logic        e_rdy;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        a_in = '0; a_iv = 0; a_stall = '0; a_flush = '0; a_clr = 0;
        b_in = '0; b_iv = 0; b_stall = '0; b_flush = '0; b_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 nRST = 0;
        step();
        #2 nRST = 1;
        step();
    endtask

    task automatic push(input logic [31:0] d);
        a_in = d; a_iv = 1;
        step();
        a_iv = 0; a_in = '0;
    endtask

    function automatic logic [31:0] sd(input int k);
        return a_sd[k*32 +: 32];
    endfunction

    initial begin
        vecs[0] = '{4'h0, 4'h0, 32'h10, 1, 32'h0,  0, 4'b0001, 1};
        vecs[1] = '{4'h0, 4'h0, 32'h11, 1, 32'h0,  0, 4'b0011, 1};
        vecs[2] = '{4'h0, 4'h0, 32'h12, 1, 32'h0,  0, 4'b0111, 1};
        vecs[3] = '{4'h0, 4'h0, 32'h0,  0, 32'h10, 1, 4'b1110, 1};
        vecs[4] = '{4'h0, 4'h0, 32'h0,  0, 32'h11, 1, 4'b1100, 1};
        vecs[5] = '{4'h0, 4'h0, 32'h0,  0, 32'h12, 1, 4'b1000, 1};
        vecs[6] = '{4'h0, 4'h0, 32'h0,  0, 32'h0,  0, 4'b0000, 1};

        idle_inputs();
        do_reset();
        chk("rst_sv", a_sv, 4'b0);
        chk("rst_sd", a_sd, 128'h0);
        chk("rst_cnt", a_cnt, 16'h0);
        chk("rst_rdy", a_rdy, 1'b1);
        chk("rst_b_ov", b_ov, 1'b0);

        // streaming
        for (int i = 0; i < 7; i++) begin
            a_stall = vecs[i].stall;
            a_flush = vecs[i].flush;
            a_in = vecs[i].din;
            a_iv = vecs[i].iv;
            step();
            chk($sformatf("v%0d_out", i), a_out, vecs[i].e_out);
            chk($sformatf("v%0d_ov", i), a_ov, vecs[i].e_ov);
            chk($sformatf("v%0d_sv", i), a_sv, vecs[i].e_sv);
            chk($sformatf("v%0d_rdy", i), a_rdy, vecs[i].e_rdy);
        end

        // stall[1] for one cycle: bubble into s2
        do_reset();
        push(32'hA0);
        push(32'hA1);
        a_stall = 4'b0010; a_in = 32'hA2; a_iv = 1;
        #1;
        chk("st_rdy", a_rdy, 1'b0);
        step();
        chk("st_s0", sd(0), 32'hA1);
        chk("st_s1", sd(1), 32'hA0);
        chk("st_s2", sd(2), 32'h0);
        chk("st_sv", a_sv, 4'b0011);
        chk("st_cnt", a_cnt, 16'd1);
        a_stall = 4'b0000;
        step();
        a_iv = 0; a_in = '0;
        chk("st2_sd", a_sd[95:0], {32'hA0, 32'hA1, 32'hA2});
        chk("st2_sv", a_sv, 4'b0111);
        step();
        chk("st3_out", a_out, 32'hA0);
        chk("st3_ov", a_ov, 1'b1);
        step();
        chk("st4_out", a_out, 32'hA1);

        // flush 0011 during stall[1]
        do_reset();
        push(32'hB0);
        push(32'hB1);
        push(32'hB2);
        a_stall = 4'b0010; a_flush = 4'b0011;
        a_in = 32'hB3; a_iv = 1;
        step();
        a_stall = '0; a_flush = '0; a_iv = 0;
        chk("fl_sv", a_sv, 4'b1000);
        chk("fl_sd", a_sd, {32'hB0, 96'h0});
        chk("fl_cnt", a_cnt, 16'd1);

        // async reset mid-stall with all stages valid
        do_reset();
        push(32'hC0);
        push(32'hC1);
        push(32'hC2);
        push(32'hC3);
        chk("ar_full", a_sv, 4'b1111);
        a_stall = 4'b1000;
        step();
        chk("ar_cnt1", a_cnt, 16'd1);
        #2 nRST = 0;
        #1;
        chk("ar_sv", a_sv, 4'b0);
        chk("ar_sd", a_sd, 128'h0);
        chk("ar_ov", a_ov, 1'b0);
        chk("ar_cnt", a_cnt, 16'h0);
        chk("ar_rdy", a_rdy, 1'b0);
        step();
        #2 nRST = 1;
        a_stall = '0;
        step();

        // hold counter saturation and clear
        a_stall = 4'b1000;
        for (int i = 0; i < 65534; i++) step();
        chk("sat_pre", a_cnt, 16'hFFFE);
        for (int i = 0; i < 4466; i++) step();
        chk("sat", a_cnt, 16'hFFFF);
        a_clr = 1;
        step();
        chk("clr", a_cnt, 16'h0);
        a_clr = 0;
        step();
        chk("clr_inc", a_cnt, 16'h1);
        a_stall = '0;
        step();
        chk("clr_idle", a_cnt, 16'h1);

        // single-stage build
        do_reset();
        b_in = 32'h3; b_iv = 1;
        step();
        chk("b_load", b_out, 32'h3);
        b_stall = 1'b1; b_in = 32'h5;
        #1;
        chk("b_rdy", b_rdy, 1'b0);
        step();
        chk("b_hold", b_out, 32'h3);
        chk("b_hold_v", b_ov, 1'b1);
        chk("b_cnt", b_cnt, 16'h1);
        b_stall = 1'b0;
        step();
        chk("b_new", b_out, 32'h5);
        chk("b_sd", b_sd, 32'h5);
        b_iv = 0;
        step();
        chk("b_empty", b_sv, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
